// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Frame is F*BIT_TICKS cycles after the accept edge; loads are only taken while idle (ready_out), never queued.
module serial_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int BIT_TICKS = 4,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_in,
    output logic              ready_out,
    input  logic              abort_in,
    output logic              tx_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state, state_n;
    logic [TICK_W-1:0]   tick_cnt, tick_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [DATA_W-1:0]   shift_reg, shift_n;
    logic                par_bit, par_n;
    logic                tx_n, ready_n, busy_n, done_n;
    logic                tick_last;

    assign tick_last = (tick_cnt == TICK_LAST);

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        par_n   = par_bit;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (load_in && ready_out) begin
                    state_n = START;
                    tick_n  = '0;
                    bit_n   = '0;
                    shift_n = data_in;
                    par_n   = ^data_in;
                end
            end
            START: begin
                if (tick_last) begin
                    tick_n  = '0;
                    state_n = DATA;
                end else begin
                    tick_n = tick_cnt + TICK_W'(1);
                end
            end
            DATA: begin
                if (tick_last) begin
                    tick_n  = '0;
                    shift_n = shift_reg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_n   = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    tick_n = tick_cnt + TICK_W'(1);
                end
            end
            PARITY: begin
                if (tick_last) begin
                    tick_n  = '0;
                    state_n = STOP;
                end else begin
                    tick_n = tick_cnt + TICK_W'(1);
                end
            end
            STOP: begin
                if (tick_last) begin
                    tick_n  = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    tick_n = tick_cnt + TICK_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tick_n  = '0;
                bit_n   = '0;
            end
        endcase

        // Line level is derived from the next state so tx_out stays a pure register.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset_in || abort_in) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx_out    <= 1'b1;
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            par_bit   <= par_n;
            tx_out    <= tx_n;
            ready_out <= ready_n;
            busy_out  <= busy_n;
            done_out  <= done_n;
        end
    end

endmodule
